// File: rtl/sync_divider4_if.sv
// rtl/sync_divider4_if.sv - start/busy/done handshake and operand/result bundle for sync_divider4
interface sync_divider4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, x, y,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, x, y,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/sync_divider4.sv
// rtl/sync_divider4.sv - sequential restoring divider, one quotient bit per clock
// Define SYNC_DIVIDER_SIGNED_EN for two's complement operands (magnitude core plus sign fix-up).
module sync_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           rst_b,
  sync_divider4_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic [WIDTH-1:0] r_zero;

  // quo_q starts as the dividend and is shifted out MSB-first as quotient bits enter at the LSB
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, y_q});
  assign rem_d   = ge ? WIDTH'(shifted - {1'b0, y_q}) : WIDTH'(shifted);
  assign quo_d   = {quo_q[WIDTH-2:0], ge};

`ifdef SYNC_DIVIDER_SIGNED_EN
  logic sx_q;
  logic sq_q;

  assign x_mag  = bus.x[WIDTH-1] ? -bus.x : bus.x;
  assign y_mag  = bus.y[WIDTH-1] ? -bus.y : bus.y;
  assign q_fin  = sq_q ? -quo_d : quo_d;
  assign r_fin  = sx_q ? -rem_d : rem_d;
  // quo_q still holds |x| when y = 0, so re-applying the sign recovers x
  assign r_zero = sx_q ? -quo_q : quo_q;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      sx_q <= 1'b0;
      sq_q <= 1'b0;
    end else if (bus.start && (state_q != RUN)) begin
      sx_q <= bus.x[WIDTH-1];
      sq_q <= bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
    end
  end
`else
  assign x_mag  = bus.x;
  assign y_mag  = bus.y;
  assign q_fin  = quo_d;
  assign r_fin  = rem_d;
  assign r_zero = quo_q;
`endif

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            y_q     <= y_mag;
            quo_q   <= x_mag;
            rem_q   <= '0;
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (y_q == '0) begin
            q_q     <= '1;
            r_q     <= r_zero;
            dbz_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              q_q     <= q_fin;
              r_q     <= r_fin;
              dbz_q   <= 1'b0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.q           = q_q;
  assign bus.r           = r_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sync_divider4.sv
// tb/tb_sync_divider4.sv - randomized self-checking bench for sync_divider4 against an arithmetic model
module tb_sync_divider4;
  logic clk;
  logic rst_b;
  int   checks;
  int   errors;
  logic [3:0] last_q;
  logic [3:0] last_r;

  sync_divider4_if #(.WIDTH(4)) bus ();

  sync_divider4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model(input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] eq, output logic [3:0] er, output logic ez);
`ifdef SYNC_DIVIDER_SIGNED_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) begin
      eq = 4'hF;
      er = a;
    end else if (sa == -8 && sb == -1) begin
      eq = 4'h8;
      er = 4'h0;
    end else begin
      eq = 4'(sa / sb);
      er = 4'(sa % sb);
    end
`else
    eq = (b == 0) ? 4'hF : a / b;
    er = (b == 0) ? a : a % b;
`endif
    ez = (b == 0);
  endfunction

  // b2b = 1 launches at the current time (caller is just past the done edge or idle)
  task automatic op(input logic [3:0] a, input logic [3:0] b, input bit b2b);
    logic [3:0] eq;
    logic [3:0] er;
    logic       ez;
    int         lat;
    int         exp_lat;
    model(a, b, eq, er, ez);
    exp_lat = (b == 0) ? 1 : 4;
    if (!b2b) @(negedge clk);
    bus.start = 1'b1;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = 4'($urandom);
    bus.y     = 4'($urandom);
    check("busy_acc", bus.busy, 1);
    check("done_acc", bus.done, 0);
    lat = 0;
    while (lat < 12) begin
      check("hold_q", bus.q, last_q);
      check("hold_r", bus.r, last_r);
      bus.start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    check("latency", lat, exp_lat);
    check("q", bus.q, eq);
    check("r", bus.r, er);
    check("dbz", bus.div_by_zero, ez);
    check("busy_done", bus.busy, 0);
    last_q = eq;
    last_r = er;
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1;
    check("done_pulse", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_q", bus.q, last_q);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    last_q    = 4'h0;
    last_r    = 4'h0;
    bus.start = 1'b0;
    bus.x     = 4'h0;
    bus.y     = 4'h0;
    rst_b     = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;

    op(4'd13, 4'd4, 1'b0);
    idle_check();
    op(4'd7, 4'd12, 1'b0);
    op(4'd15, 4'd1, 1'b1);
    idle_check();
    op(4'd9, 4'd0, 1'b0);
    idle_check();
    op(4'd8, 4'd2, 1'b0);
    op(4'd0, 4'd5, 1'b1);
    op(4'd3, 4'd0, 1'b1);
    op(4'd2, 4'd9, 1'b1);
`ifdef SYNC_DIVIDER_SIGNED_EN
    op(4'h9, 4'h2, 1'b0);
    op(4'h8, 4'hF, 1'b1);
    op(4'h7, 4'hE, 1'b1);
`endif
    idle_check();

    // reset between edges 2 and 3 of an operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 4'd13;
    bus.y     = 4'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_b = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_q", bus.q, 0);
    check("mid_rst_r", bus.r, 0);
    check("mid_rst_done", bus.done, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("mid_rst_nodone", bus.done, 0);
    end
    @(negedge clk);
    rst_b  = 1'b0;
    last_q = 4'h0;
    last_r = 4'h0;
    idle_check();

    for (int i = 0; i < 40; i++) begin
      op(4'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_check();
    end
    idle_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
